// File: rtl/unum4_pack.sv
// unum4 output packer: rounds the adder's normalized mantissa to the field width
// left over after a minimal-width exponent and packs one DATA_W-bit unum4 word.
// Three register stages: input/exponent sizing, rounding, renormalize/pack.
// Sizing relations: EXP_MAX_W == 2**EXP_SZ_W, DATA_W-EXP_SZ_W-EXP_MAX_W >= 2,
// and MAN_MAX_W+EXTRA >= DATA_W-EXP_SZ_W-1 (the widest fraction field).
module unum4_pack #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAN_MAX_W = 29,
    parameter int unsigned EXP_SZ_W  = 4,
    parameter int unsigned EXP_MAX_W = 16,
    parameter int unsigned EXTRA     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MAN_MAX_W+EXTRA-1:0]    m_i,
    input  logic [EXP_MAX_W-1:0]          e_i,
    input  logic                          over_i,
    input  logic                          under_i,
    output logic                          done,
    output logic [DATA_W-1:0]             data_o,
    output logic                          over_o,
    output logic                          under_o,
    output logic                          inexact_o
);

    localparam int unsigned MW   = MAN_MAX_W + EXTRA;
    // Two zero LSBs appended so guard/sticky positions always exist.
    localparam int unsigned MXW  = MW + 2;
    localparam int unsigned WW   = EXP_SZ_W + 1;
    localparam int unsigned FMAX = DATA_W - EXP_SZ_W - 1;
    localparam int unsigned FMIN = DATA_W - EXP_SZ_W - EXP_MAX_W;

    localparam logic [EXP_MAX_W-1:0] EMAX = {1'b0, {(EXP_MAX_W-1){1'b1}}};
    localparam logic [EXP_MAX_W-1:0] EMIN = {1'b1, {(EXP_MAX_W-1){1'b0}}};

    // Smallest signed width that holds e (1..EXP_MAX_W).
    function automatic logic [WW-1:0] exp_width(input logic [EXP_MAX_W-1:0] e);
        logic [WW-1:0]        w;
        logic [EXP_MAX_W-1:0] t;
        w = WW'(EXP_MAX_W);
        for (int n = EXP_MAX_W - 1; n >= 1; n--) begin
            t = $signed(e) >>> (n - 1);
            if (t == '0 || t == '1) w = WW'(n);
        end
        return w;
    endfunction

    // Fraction field width left for an exponent of width w.
    function automatic logic [31:0] f_of_w(input logic [WW-1:0] w);
        return 32'(DATA_W - EXP_SZ_W) - 32'(w);
    endfunction

    // Assemble {es, exp[w-1:0], man[F-1:0]}.
    function automatic logic [DATA_W-1:0] pack(input logic [WW-1:0]        w,
                                               input logic [EXP_MAX_W-1:0] e,
                                               input logic [FMAX-1:0]      man);
        logic [31:0]       f;
        logic [DATA_W-1:0] es_f;
        logic [DATA_W-1:0] e_f;
        logic [DATA_W-1:0] m_f;
        f    = f_of_w(w);
        es_f = DATA_W'(w - WW'(1)) << (DATA_W - EXP_SZ_W);
        e_f  = (DATA_W'(e) & ((DATA_W'(1) << w) - DATA_W'(1))) << f;
        m_f  = DATA_W'(man) & ((DATA_W'(1) << f) - DATA_W'(1));
        return es_f | e_f | m_f;
    endfunction

    // Saturated word for the given sign.
    function automatic logic [DATA_W-1:0] sat_word(input logic neg);
        logic [FMAX-1:0] man;
        man = FMAX'(1) << (FMIN - 1);
        if (!neg) man = man - FMAX'(1);
        return pack(WW'(EXP_MAX_W), EMAX, man);
    endfunction

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [MW-1:0]        s1_m_q, s1_m_d;
    logic [EXP_MAX_W-1:0] s1_e_q, s1_e_d;
    logic [WW-1:0]        s1_w_q, s1_w_d;
    logic                 s1_over_q, s1_over_d;
    logic                 s1_under_q, s1_under_d;

    // Stage 2 state
    logic                 s2_valid_q, s2_valid_d;
    logic [EXP_MAX_W-1:0] s2_e_q, s2_e_d;
    logic [FMAX-1:0]      s2_man_q, s2_man_d;
    logic                 s2_over_q, s2_over_d;
    logic                 s2_under_q, s2_under_d;
    logic                 s2_zero_q, s2_zero_d;
    logic                 s2_sign_q, s2_sign_d;
    logic                 s2_inexact_q, s2_inexact_d;
    logic                 s2_carry_q, s2_carry_d;
    logic                 s2_negnorm_q, s2_negnorm_d;

    // Output state
    logic                 done_q, done_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 over_q, over_d;
    logic                 under_q, under_d;
    logic                 inexact_q, inexact_d;

    // Stage 1: capture operand and size its exponent.
    always_comb begin
        s1_valid_d = start;
        s1_m_d     = m_i;
        s1_e_d     = e_i;
        s1_w_d     = exp_width(e_i);
        s1_over_d  = over_i;
        s1_under_d = under_i;
    end

    // Stage 2: keep top F bits, round to nearest even, flag renormalization cases.
    logic [MXW-1:0]        mx;
    logic [31:0]           f1;
    logic [31:0]           sh;
    logic signed [MXW-1:0] kept;
    logic [MXW-1:0]        low_mask;
    logic [MXW-1:0]        rounded;
    logic [MXW-1:0]        neg_tgt;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;

    always_comb begin
        mx       = {s1_m_q, 2'b00};
        f1       = f_of_w(s1_w_q);
        sh       = 32'(MXW) - f1;
        kept     = $signed(mx) >>> sh;
        guard    = |(mx & (MXW'(1) << (sh - 32'd1)));
        low_mask = (MXW'(1) << (sh - 32'd1)) - MXW'(1);
        sticky   = |(mx & low_mask);
        round_up = guard & (sticky | kept[0]);
        rounded  = kept + MXW'(round_up);
        // -2^(F-2): the F-bit pattern 1100..0 sign-extended.
        neg_tgt  = ~((MXW'(1) << (f1 - 32'd2)) - MXW'(1));

        s2_valid_d   = s1_valid_q;
        s2_e_d       = s1_e_q;
        s2_man_d     = rounded[FMAX-1:0];
        s2_over_d    = s1_over_q;
        s2_under_d   = s1_under_q;
        s2_zero_d    = (s1_m_q == '0);
        s2_sign_d    = s1_m_q[MW-1];
        s2_inexact_d = guard | sticky;
        s2_carry_d   = (rounded == (MXW'(1) << (f1 - 32'd1)));
        s2_negnorm_d = round_up && (rounded == neg_tgt) && (s1_e_q != EMIN);
    end

    // Stage 3: renormalize, handle specials, pack; outputs hold while idle.
    logic [EXP_MAX_W-1:0] e_new;
    logic [WW-1:0]        w_new;
    logic [31:0]          f_new;
    logic [FMAX-1:0]      man_new;

    always_comb begin
        e_new   = s2_e_q;
        man_new = s2_man_q;
        if (s2_carry_q) begin
            e_new = s2_e_q + EXP_MAX_W'(1);
        end else if (s2_negnorm_q) begin
            e_new = s2_e_q - EXP_MAX_W'(1);
        end
        w_new = exp_width(e_new);
        f_new = f_of_w(w_new);
        // Renormalized mantissas are exact patterns, so regenerate them at the new width.
        if (s2_carry_q) begin
            man_new = FMAX'(1) << (f_new - 32'd2);
        end else if (s2_negnorm_q) begin
            man_new = FMAX'(1) << (f_new - 32'd1);
        end

        done_d    = s2_valid_q;
        data_d    = data_q;
        over_d    = over_q;
        under_d   = under_q;
        inexact_d = inexact_q;
        if (s2_valid_q) begin
            over_d    = 1'b0;
            under_d   = 1'b0;
            inexact_d = 1'b0;
            if (s2_over_q) begin
                data_d = sat_word(s2_sign_q);
                over_d = 1'b1;
            end else if (s2_under_q) begin
                data_d  = '0;
                under_d = 1'b1;
            end else if (s2_zero_q) begin
                data_d = '0;
            end else if (s2_carry_q && (s2_e_q == EMAX)) begin
                data_d    = sat_word(1'b0);
                over_d    = 1'b1;
                inexact_d = s2_inexact_q;
            end else begin
                data_d    = pack(w_new, e_new, man_new);
                inexact_d = s2_inexact_q;
            end
        end
    end

    // Pipeline registers; reset clears every valid bit and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_e_q       <= '0;
            s1_w_q       <= '0;
            s1_over_q    <= 1'b0;
            s1_under_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_e_q       <= '0;
            s2_man_q     <= '0;
            s2_over_q    <= 1'b0;
            s2_under_q   <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_inexact_q <= 1'b0;
            s2_carry_q   <= 1'b0;
            s2_negnorm_q <= 1'b0;
            done_q       <= 1'b0;
            data_q       <= '0;
            over_q       <= 1'b0;
            under_q      <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_m_q       <= s1_m_d;
            s1_e_q       <= s1_e_d;
            s1_w_q       <= s1_w_d;
            s1_over_q    <= s1_over_d;
            s1_under_q   <= s1_under_d;
            s2_valid_q   <= s2_valid_d;
            s2_e_q       <= s2_e_d;
            s2_man_q     <= s2_man_d;
            s2_over_q    <= s2_over_d;
            s2_under_q   <= s2_under_d;
            s2_zero_q    <= s2_zero_d;
            s2_sign_q    <= s2_sign_d;
            s2_inexact_q <= s2_inexact_d;
            s2_carry_q   <= s2_carry_d;
            s2_negnorm_q <= s2_negnorm_d;
            done_q       <= done_d;
            data_q       <= data_d;
            over_q       <= over_d;
            under_q      <= under_d;
            inexact_q    <= inexact_d;
        end
    end

    assign done      = done_q;
    assign data_o    = data_q;
    assign over_o    = over_q;
    assign under_o   = under_q;
    assign inexact_o = inexact_q;

endmodule

// File: tb/tb_unum4_pack.sv
// Directed bench for unum4_pack: hand-computed vectors, latency, ordering and reset.
module tb_unum4_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [28:0] m_i = '0;
    logic [15:0] e_i = '0;
    logic        over_i = 1'b0;
    logic        under_i = 1'b0;
    logic        done;
    logic [31:0] data_o;
    logic        over_o;
    logic        under_o;
    logic        inexact_o;

    unum4_pack #(
        .DATA_W    (32),
        .MAN_MAX_W (29),
        .EXP_SZ_W  (4),
        .EXP_MAX_W (16),
        .EXTRA     (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m_i       (m_i),
        .e_i       (e_i),
        .over_i    (over_i),
        .under_i   (under_i),
        .done      (done),
        .data_o    (data_o),
        .over_o    (over_o),
        .under_o   (under_o),
        .inexact_o (inexact_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] m;
        logic [15:0] e;
        logic        ov;
        logic        un;
        logic [31:0] data;
        logic        xo;
        logic        xu;
        logic        xi;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int i);
        m_i     = vecs[i].m;
        e_i     = vecs[i].e;
        over_i  = vecs[i].ov;
        under_i = vecs[i].un;
        start   = 1'b1;
    endtask

    task automatic check_out(input int i);
        check($sformatf("v%0d.done", i), 32'(done), 32'd1);
        check($sformatf("v%0d.data", i), data_o, vecs[i].data);
        check($sformatf("v%0d.over", i), 32'(over_o), 32'(vecs[i].xo));
        check($sformatf("v%0d.under", i), 32'(under_o), 32'(vecs[i].xu));
        check($sformatf("v%0d.inexact", i), 32'(inexact_o), 32'(vecs[i].xi));
    endtask

    // One isolated operand: exact latency, output values, single-cycle done, hold.
    task automatic run_vec(input int i);
        @(negedge clk);
        drive(i);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d.early", i), 32'(done), 32'd0);
        @(negedge clk);
        check_out(i);
        @(negedge clk);
        check($sformatf("v%0d.pulse", i), 32'(done), 32'd0);
        check($sformatf("v%0d.hold", i), data_o, vecs[i].data);
    endtask

    initial begin
        int pulses;
        //            m             e         ov    un    data           o     u     x
        vecs[0]  = '{29'h08000000, 16'h0000, 1'b0, 1'b0, 32'h02000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{29'h08000000, 16'h0005, 1'b0, 1'b0, 32'h35400000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{29'h0FFFFFFF, 16'h0000, 1'b0, 1'b0, 32'h15000000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{29'h08000000, 16'h0000, 1'b1, 1'b0, 32'hF7FFF7FF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{29'h10000000, 16'h0000, 1'b1, 1'b0, 32'hF7FFF800, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{29'h08000000, 16'h0000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{29'h00000000, 16'h0000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        // Negative round-up to 1100..0: exponent 0 -> -1.
        vecs[7]  = '{29'h17FFFFFF, 16'h0000, 1'b0, 1'b0, 32'h0C000000, 1'b0, 1'b0, 1'b1};
        // Same at the minimum exponent: stays unnormalized.
        vecs[8]  = '{29'h17FFFFFF, 16'h8000, 1'b0, 1'b0, 32'hF8000C00, 1'b0, 1'b0, 1'b1};
        // Carry-out at the maximum exponent saturates.
        vecs[9]  = '{29'h0FFFFFFF, 16'h7FFF, 1'b0, 1'b0, 32'hF7FFF7FF, 1'b1, 1'b0, 1'b1};
        // Ties: even LSB stays, odd LSB rounds up.
        vecs[10] = '{29'h08000002, 16'h0000, 1'b0, 1'b0, 32'h02000000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{29'h08000006, 16'h0000, 1'b0, 1'b0, 32'h02000002, 1'b0, 1'b0, 1'b1};
        // Negative exponent field.
        vecs[12] = '{29'h08000000, 16'hFFFD, 1'b0, 1'b0, 32'h2A800000, 1'b0, 1'b0, 1'b0};
        // Carry-out with exponent 1 -> 2 (w grows, F shrinks).
        vecs[13] = '{29'h0FFFFFFF, 16'h0001, 1'b0, 1'b0, 32'h24800000, 1'b0, 1'b0, 1'b1};
        // Negative renormalize with exponent 1 -> 0 (w shrinks, F grows).
        vecs[14] = '{29'h17FFFFFF, 16'h0001, 1'b0, 1'b0, 32'h04000000, 1'b0, 1'b0, 1'b1};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst.done", 32'(done), 32'd0);
        check("rst.data", data_o, 32'd0);
        check("rst.flags", {29'd0, over_o, under_o, inexact_o}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back starts come out back-to-back and in order.
        @(negedge clk);
        drive(0);
        @(negedge clk);
        drive(1);
        @(negedge clk);
        drive(2);
        @(negedge clk);
        start = 1'b0;
        check_out(0);
        @(negedge clk);
        check_out(1);
        @(negedge clk);
        check_out(2);
        @(negedge clk);
        check("b2b.end", 32'(done), 32'd0);

        // Same burst with a reset one cycle after the last start.
        @(negedge clk);
        drive(0);
        @(negedge clk);
        drive(1);
        @(negedge clk);
        drive(2);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.data", data_o, 32'd0);
        check("midrst.flags", {29'd0, over_o, under_o, inexact_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst.pulses", 32'(pulses), 32'd0);

        // Recovers normally afterwards.
        run_vec(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
